bram_dp_param: RTL and testbench

Parametrised true-dual-port block RAM with registered read data, selectable read-during-write behaviour, write-collision detection and a sequential hardware clear engine. Next-generation data buffer for the signed-sample processing path; replaces the fixed 1024x8 dual-port memory. The memory array is never reset directly, so it maps to inferred BRAM. Clearing is done one word per cycle by an internal FSM.

---
 rtl/bram_pkg.sv | 13 +
 rtl/bram_clear_fsm.sv | 73 +++++++
 rtl/bram_dp_param.sv | 125 ++++++++++++
 tb/tb_bram_dp_param.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared constants and clear-engine state encoding for the dual-port BRAM.
package bram_pkg;

    localparam int unsigned RDW_READ_FIRST  = 0;
    localparam int unsigned RDW_WRITE_FIRST = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

endpackage

// File: rtl/bram_clear_fsm.sv
// Sequential clear engine: walks every address once, writing CLEAR_VAL via port A,
// and takes port A away from the user while it runs.
module bram_clear_fsm
    import bram_pkg::*;
#(
    parameter int unsigned          DATA_W         = 8,
    parameter int unsigned          ADDR_W         = 10,
    parameter int unsigned          CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0]    CLEAR_VAL      = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    input  logic              user_en,
    input  logic              user_we,
    input  logic [ADDR_W-1:0] user_addr,
    input  logic [DATA_W-1:0] user_wdata,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              user_acc,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata
);

    clr_state_t        state;
    clr_state_t        nxt;
    logic [ADDR_W-1:0] cnt;
    logic              boot;

    // boot is armed by reset so the clear launches on the first clock after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            boot  <= (CLEAR_ON_RESET != 0);
        end else begin
            state <= nxt;
            boot  <= 1'b0;
            if (state != CLEAR && nxt == CLEAR) begin
                cnt <= '0;
            end else if (state == CLEAR) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (clr_req || boot) nxt = CLEAR;
            CLEAR:   if (cnt == '1) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    assign clr_busy = (state == CLEAR);
    assign clr_done = (state == DONE);
    assign user_acc = user_en && !clr_busy;

    always_comb begin
        mem_we    = user_acc && user_we;
        mem_addr  = user_addr;
        mem_wdata = user_wdata;
        if (clr_busy) begin
            mem_we    = 1'b1;
            mem_addr  = cnt;
            mem_wdata = CLEAR_VAL;
        end
    end

endmodule

// File: rtl/bram_dp_param.sv
// Parametrised true-dual-port RAM: registered reads, selectable read-during-write,
// dual-write collision flag and a sequential clear engine sharing port A.
module bram_dp_param
    import bram_pkg::*;
#(
    parameter int unsigned       DATA_W         = 8,
    parameter int unsigned       ADDR_W         = 10,
    parameter int unsigned       RDW_MODE       = 0,
    parameter int unsigned       OUT_REG        = 0,
    parameter int unsigned       A_PRIORITY     = 1,
    parameter int unsigned       CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] CLEAR_VAL      = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    input  logic              b_en,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rvalid,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              coll
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam bit          WR_FIRST = (RDW_MODE == RDW_WRITE_FIRST);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              a_acc;
    logic              a_mem_we;
    logic [ADDR_W-1:0] a_mem_addr;
    logic [DATA_W-1:0] a_mem_wdata;
    logic              b_acc;
    logic              b_wr;
    logic              a_wr;

    logic [DATA_W-1:0] a_d1;
    logic [DATA_W-1:0] b_d1;
    logic              a_v1;
    logic              b_v1;

    bram_clear_fsm #(
        .DATA_W         (DATA_W),
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET),
        .CLEAR_VAL      (CLEAR_VAL)
    ) u_clear (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req    (clr_req),
        .user_en    (a_en),
        .user_we    (a_we),
        .user_addr  (a_addr),
        .user_wdata (a_wdata),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .user_acc   (a_acc),
        .mem_we     (a_mem_we),
        .mem_addr   (a_mem_addr),
        .mem_wdata  (a_mem_wdata)
    );

    assign b_acc = b_en && !clr_busy;
    assign b_wr  = b_acc && b_we;
    assign a_wr  = a_acc && a_we;

    // Both ports share one process; the later assignment wins a same-address dual write.
    always_ff @(posedge clk) begin
        if (A_PRIORITY != 0) begin
            if (b_wr)     mem[b_addr]     <= b_wdata;
            if (a_mem_we) mem[a_mem_addr] <= a_mem_wdata;
        end else begin
            if (a_mem_we) mem[a_mem_addr] <= a_mem_wdata;
            if (b_wr)     mem[b_addr]     <= b_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_d1 <= '0;
            b_d1 <= '0;
            a_v1 <= 1'b0;
            b_v1 <= 1'b0;
            coll <= 1'b0;
        end else begin
            a_v1 <= a_acc;
            b_v1 <= b_acc;
            if (a_acc) a_d1 <= (WR_FIRST && a_we) ? a_wdata : mem[a_addr];
            if (b_acc) b_d1 <= (WR_FIRST && b_we) ? b_wdata : mem[b_addr];
            coll <= a_wr && b_wr && (a_addr == b_addr);
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_rdata  <= '0;
                b_rdata  <= '0;
                a_rvalid <= 1'b0;
                b_rvalid <= 1'b0;
            end else begin
                a_rvalid <= a_v1;
                b_rvalid <= b_v1;
                if (a_v1) a_rdata <= a_d1;
                if (b_v1) b_rdata <= b_d1;
            end
        end
    end else begin : g_no_out_reg
        assign a_rdata  = a_d1;
        assign b_rdata  = b_d1;
        assign a_rvalid = a_v1;
        assign b_rvalid = b_v1;
    end

endmodule

// File: tb/tb_bram_dp_param.sv
// Bench for bram_dp_param: a default instance and a small write-first/out-reg instance,
// checked against an array-based behavioural model.
module tb_bram_dp_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_en [2], a_we [2], b_en [2], b_we [2], clr_req [2];
    logic [9:0] a_addr [2], b_addr [2];
    logic [7:0] a_wdata [2], b_wdata [2];
    logic [7:0] a_rdata [2], b_rdata [2];
    logic       a_rvalid [2], b_rvalid [2], clr_busy [2], clr_done [2], coll [2];

    int checks = 0;
    int errors = 0;

    bram_dp_param #(
        .DATA_W(8), .ADDR_W(10), .RDW_MODE(0), .OUT_REG(0),
        .A_PRIORITY(1), .CLEAR_ON_RESET(1), .CLEAR_VAL(8'h00)
    ) dut0 (
        .clk(clk), .rst_n(rst_n),
        .a_en(a_en[0]), .a_we(a_we[0]), .a_addr(a_addr[0]), .a_wdata(a_wdata[0]),
        .a_rdata(a_rdata[0]), .a_rvalid(a_rvalid[0]),
        .b_en(b_en[0]), .b_we(b_we[0]), .b_addr(b_addr[0]), .b_wdata(b_wdata[0]),
        .b_rdata(b_rdata[0]), .b_rvalid(b_rvalid[0]),
        .clr_req(clr_req[0]), .clr_busy(clr_busy[0]), .clr_done(clr_done[0]), .coll(coll[0])
    );

    bram_dp_param #(
        .DATA_W(8), .ADDR_W(4), .RDW_MODE(1), .OUT_REG(1),
        .A_PRIORITY(0), .CLEAR_ON_RESET(0), .CLEAR_VAL(8'hFF)
    ) dut1 (
        .clk(clk), .rst_n(rst_n),
        .a_en(a_en[1]), .a_we(a_we[1]), .a_addr(a_addr[1][3:0]), .a_wdata(a_wdata[1]),
        .a_rdata(a_rdata[1]), .a_rvalid(a_rvalid[1]),
        .b_en(b_en[1]), .b_we(b_we[1]), .b_addr(b_addr[1][3:0]), .b_wdata(b_wdata[1]),
        .b_rdata(b_rdata[1]), .b_rvalid(b_rvalid[1]),
        .clr_req(clr_req[1]), .clr_busy(clr_busy[1]), .clr_done(clr_done[1]), .coll(coll[1])
    );

    // ---------------- behavioural model ----------------
    int unsigned DEPTH_M [2] = '{1024, 16};
    bit          LAT2    [2] = '{1'b0, 1'b1};
    bit          WF      [2] = '{1'b0, 1'b1};
    bit          APRI    [2] = '{1'b1, 1'b0};
    bit          COR     [2] = '{1'b1, 1'b0};
    logic [7:0]  CVAL    [2] = '{8'h00, 8'hFF};

    logic [7:0]  mm [2][1024];
    int unsigned busy_left [2];
    bit          boot [2];
    bit          e_busy [2], e_done [2], e_coll [2];
    bit          s1_av [2], s1_bv [2], e_av [2], e_bv [2];
    logic [7:0]  s1_ad [2], s1_bd [2], e_ad [2], e_bd [2];

    always @(posedge clk or negedge rst_n) begin
        bit was_busy, was_done, acc_a, acc_b, wa, wb;
        logic [7:0] ra, rb;
        int unsigned ia, ib;
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                busy_left[d] = 0; boot[d] = COR[d];
                e_busy[d] = 0; e_done[d] = 0; e_coll[d] = 0;
                s1_av[d] = 0; s1_bv[d] = 0; e_av[d] = 0; e_bv[d] = 0;
                s1_ad[d] = '0; s1_bd[d] = '0; e_ad[d] = '0; e_bd[d] = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                was_busy = (busy_left[d] != 0);
                was_done = e_done[d];
                ia = a_addr[d] % DEPTH_M[d];
                ib = b_addr[d] % DEPTH_M[d];
                acc_a = a_en[d] && !was_busy;
                acc_b = b_en[d] && !was_busy;
                ra = (WF[d] && a_we[d]) ? a_wdata[d] : mm[d][ia];
                rb = (WF[d] && b_we[d]) ? b_wdata[d] : mm[d][ib];
                wa = acc_a && a_we[d];
                wb = acc_b && b_we[d];
                e_coll[d] = wa && wb && (ia == ib);
                if (wa && wb && ia == ib) begin
                    mm[d][ia] = APRI[d] ? a_wdata[d] : b_wdata[d];
                end else begin
                    if (wa) mm[d][ia] = a_wdata[d];
                    if (wb) mm[d][ib] = b_wdata[d];
                end
                if (LAT2[d]) begin
                    e_av[d] = s1_av[d]; e_bv[d] = s1_bv[d];
                    if (s1_av[d]) e_ad[d] = s1_ad[d];
                    if (s1_bv[d]) e_bd[d] = s1_bd[d];
                end
                s1_av[d] = acc_a; s1_bv[d] = acc_b;
                if (acc_a) s1_ad[d] = ra;
                if (acc_b) s1_bd[d] = rb;
                if (!LAT2[d]) begin
                    e_av[d] = s1_av[d]; e_bv[d] = s1_bv[d];
                    e_ad[d] = s1_ad[d]; e_bd[d] = s1_bd[d];
                end
                e_done[d] = 0;
                if (was_busy) begin
                    busy_left[d] = busy_left[d] - 1;
                    if (busy_left[d] == 0) begin
                        for (int unsigned i = 0; i < DEPTH_M[d]; i++) mm[d][i] = CVAL[d];
                        e_done[d] = 1;
                    end
                end else if (!was_done && (boot[d] || clr_req[d])) begin
                    busy_left[d] = DEPTH_M[d];
                end
                boot[d] = 0;
                e_busy[d] = (busy_left[d] != 0);
            end
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            a_en[d] = 0; a_we[d] = 0; b_en[d] = 0; b_we[d] = 0; clr_req[d] = 0;
        end
    endtask

    task automatic wait_clear(input int d, output int n, output bit seen);
        n = 0;
        seen = 0;
        for (int c = 0; c < 1200 && !seen; c++) begin
            tick();
            clr_req[d] = 0;
            if (clr_busy[d]) n++;
            else if (clr_done[d]) seen = 1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({a_rdata[d], b_rdata[d], a_rvalid[d], b_rvalid[d], clr_busy[d], clr_done[d], coll[d]} !== 21'd0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got %h/%h v%b%b busy%b done%b coll%b, expected all zero",
                         d, a_rdata[d], b_rdata[d], a_rvalid[d], b_rvalid[d], clr_busy[d], clr_done[d], coll[d]);
            end
        end
    endtask

    task automatic test_boot_clear();
        int n;
        bit seen;
        @(negedge clk);
        rst_n = 1;
        wait_clear(0, n, seen);
        checks++;
        if (!seen || n != 1024) begin
            errors++;
            $display("FAIL boot_clear_len: busy cycles %0d done_seen %0d, expected 1024 and 1", n, seen);
        end
        checks++;
        if (clr_busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL no_boot_clear dut1: clr_busy %b, expected 0", clr_busy[1]);
        end
        tick();
        checks++;
        if (clr_done[0] !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width: clr_done %b, expected 0", clr_done[0]);
        end
        clr_req[1] = 1;
        wait_clear(1, n, seen);
        checks++;
        if (!seen || n != 16) begin
            errors++;
            $display("FAIL req_clear_len dut1: busy cycles %0d done_seen %0d, expected 16 and 1", n, seen);
        end
    endtask

    task automatic test_read_all();
        for (int i = 0; i <= 1024; i++) begin
            idle();
            if (i < 1024) begin
                for (int d = 0; d < 2; d++) begin
                    a_en[d] = 1; a_addr[d] = 10'(i);
                    b_en[d] = 1; b_addr[d] = 10'(1023 - i);
                end
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (a_rvalid[d] !== e_av[d] || b_rvalid[d] !== e_bv[d] ||
                    a_rdata[d] !== e_ad[d] || b_rdata[d] !== e_bd[d]) begin
                    errors++;
                    $display("FAIL read_all dut%0d i=%0d: got A %b/%h B %b/%h, expected A %b/%h B %b/%h",
                             d, i, a_rvalid[d], a_rdata[d], b_rvalid[d], b_rdata[d],
                             e_av[d], e_ad[d], e_bv[d], e_bd[d]);
                end
            end
        end
        checks++;
        if (b_rdata[0] !== 8'h00 || b_rdata[1] !== 8'hFF) begin
            errors++;
            $display("FAIL clear_value: got %h/%h, expected 00/ff", b_rdata[0], b_rdata[1]);
        end
        idle();
        tick();
    endtask

    task automatic test_write_read();
        idle();
        for (int d = 0; d < 2; d++) begin
            a_en[d] = 1; a_we[d] = 1; a_addr[d] = 10'd5; a_wdata[d] = 8'h7F;
        end
        tick();
        checks++;
        if (a_rvalid[0] !== 1'b1 || a_rdata[0] !== 8'h00) begin
            errors++;
            $display("FAIL write_rvalid dut0: got %b/%h, expected 1/00", a_rvalid[0], a_rdata[0]);
        end
        idle();
        for (int d = 0; d < 2; d++) begin
            b_en[d] = 1; b_addr[d] = 10'd5;
        end
        tick();
        checks++;
        if (b_rvalid[0] !== 1'b1 || b_rdata[0] !== 8'h7F) begin
            errors++;
            $display("FAIL b_read_lat1 dut0: got %b/%h, expected 1/7f", b_rvalid[0], b_rdata[0]);
        end
        checks++;
        if (a_rvalid[1] !== 1'b1 || a_rdata[1] !== 8'h7F || b_rvalid[1] !== 1'b0) begin
            errors++;
            $display("FAIL lat2_stage dut1: got A %b/%h Bv %b, expected 1/7f Bv 0",
                     a_rvalid[1], a_rdata[1], b_rvalid[1]);
        end
        idle();
        tick();
        checks++;
        if (b_rvalid[1] !== 1'b1 || b_rdata[1] !== 8'h7F) begin
            errors++;
            $display("FAIL b_read_lat2 dut1: got %b/%h, expected 1/7f", b_rvalid[1], b_rdata[1]);
        end
        checks++;
        if (b_rvalid[0] !== 1'b0 || b_rdata[0] !== 8'h7F) begin
            errors++;
            $display("FAIL rdata_hold dut0: got %b/%h, expected 0/7f", b_rvalid[0], b_rdata[0]);
        end
        tick();
    endtask

    task automatic test_collision();
        idle();
        for (int d = 0; d < 2; d++) begin
            a_en[d] = 1; a_we[d] = 1; a_addr[d] = 10'd9; a_wdata[d] = 8'h11;
            b_en[d] = 1; b_we[d] = 1; b_addr[d] = 10'd9; b_wdata[d] = 8'h22;
        end
        tick();
        checks++;
        if (coll[0] !== 1'b1 || coll[1] !== 1'b1) begin
            errors++;
            $display("FAIL coll_pulse: got %b/%b, expected 1/1", coll[0], coll[1]);
        end
        idle();
        for (int d = 0; d < 2; d++) begin
            a_en[d] = 1; a_addr[d] = 10'd9;
            b_en[d] = 1; b_we[d] = 1; b_addr[d] = 10'd10; b_wdata[d] = 8'h33;
        end
        a_we[0] = 1; a_addr[0] = 10'd12; a_wdata[0] = 8'h44;
        tick();
        checks++;
        if (coll[0] !== 1'b0 || coll[1] !== 1'b0) begin
            errors++;
            $display("FAIL coll_clear: got %b/%b, expected 0/0", coll[0], coll[1]);
        end
        idle();
        a_en[0] = 1; a_addr[0] = 10'd9;
        tick();
        checks++;
        if (a_rdata[0] !== 8'h11 || coll[0] !== 1'b0) begin
            errors++;
            $display("FAIL coll_data_a dut0: got %h coll %b, expected 11 coll 0", a_rdata[0], coll[0]);
        end
        checks++;
        if (a_rdata[1] !== 8'h22) begin
            errors++;
            $display("FAIL coll_data_b dut1: got %h, expected 22", a_rdata[1]);
        end
        idle();
        tick();
    endtask

    task automatic test_rdw();
        idle();
        for (int d = 0; d < 2; d++) begin
            a_en[d] = 1; a_we[d] = 1; a_addr[d] = 10'd3; a_wdata[d] = 8'h40;
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            a_wdata[d] = 8'h81;
            b_en[d] = 1; b_addr[d] = 10'd3;
        end
        tick();
        checks++;
        if (a_rdata[0] !== 8'h40 || b_rdata[0] !== 8'h40) begin
            errors++;
            $display("FAIL read_first dut0: got A %h B %h, expected 40 40", a_rdata[0], b_rdata[0]);
        end
        idle();
        tick();
        checks++;
        if (a_rdata[1] !== 8'h81 || b_rdata[1] !== 8'h40) begin
            errors++;
            $display("FAIL write_first dut1: got A %h B %h, expected 81 40", a_rdata[1], b_rdata[1]);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 2; d++) begin
                a_en[d] = ($urandom_range(0, 3) != 0);
                a_we[d] = $urandom_range(0, 1) == 1;
                a_addr[d] = 10'($urandom_range(0, 15));
                a_wdata[d] = 8'($urandom);
                b_en[d] = ($urandom_range(0, 3) != 0);
                b_we[d] = $urandom_range(0, 1) == 1;
                b_addr[d] = 10'($urandom_range(0, 15));
                b_wdata[d] = 8'($urandom);
                clr_req[d] = 0;
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({a_rvalid[d], b_rvalid[d], coll[d], clr_busy[d], clr_done[d]} !==
                    {e_av[d], e_bv[d], e_coll[d], e_busy[d], e_done[d]} ||
                    a_rdata[d] !== e_ad[d] || b_rdata[d] !== e_bd[d]) begin
                    errors++;
                    $display("FAIL random dut%0d cyc %0d: got v%b%b coll%b A %h B %h, expected v%b%b coll%b A %h B %h",
                             d, c, a_rvalid[d], b_rvalid[d], coll[d], a_rdata[d], b_rdata[d],
                             e_av[d], e_bv[d], e_coll[d], e_ad[d], e_bd[d]);
                end
            end
        end
        idle();
        tick();
        tick();
    endtask

    task automatic test_clear_ignored();
        int n [2];
        bit seen [2];
        n = '{0, 0};
        seen = '{0, 0};
        idle();
        for (int d = 0; d < 2; d++) begin
            clr_req[d] = 1;
            a_en[d] = 1; a_addr[d] = 10'd5;
        end
        for (int c = 0; c < 1200 && !(seen[0] && seen[1]); c++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({a_rvalid[d], b_rvalid[d], clr_busy[d], clr_done[d]} !==
                    {e_av[d], e_bv[d], e_busy[d], e_done[d]} ||
                    a_rdata[d] !== e_ad[d] || b_rdata[d] !== e_bd[d]) begin
                    errors++;
                    $display("FAIL busy_ignore dut%0d cyc %0d: got v%b%b busy%b done%b A %h B %h, expected v%b%b busy%b done%b A %h B %h",
                             d, c, a_rvalid[d], b_rvalid[d], clr_busy[d], clr_done[d], a_rdata[d], b_rdata[d],
                             e_av[d], e_bv[d], e_busy[d], e_done[d], e_ad[d], e_bd[d]);
                end
                if (clr_busy[d]) n[d]++;
                else if (clr_done[d]) seen[d] = 1;
            end
            idle();
            if (c == 3) begin
                for (int d = 0; d < 2; d++) begin
                    b_en[d] = 1; b_we[d] = 1; b_addr[d] = 10'd0; b_wdata[d] = 8'h12;
                end
            end
            if (c == 6) begin
                clr_req[0] = 1;
                clr_req[1] = 1;
            end
        end
        checks++;
        if (!seen[0] || n[0] != 1024 || !seen[1] || n[1] != 16) begin
            errors++;
            $display("FAIL no_restart: busy %0d/%0d done %0d/%0d, expected 1024/16 and 1/1",
                     n[0], n[1], seen[0], seen[1]);
        end
        idle();
        for (int d = 0; d < 2; d++) begin
            b_en[d] = 1; b_addr[d] = 10'd0;
        end
        tick();
        idle();
        tick();
        checks++;
        if (b_rdata[0] !== 8'h00 || b_rdata[1] !== 8'hFF) begin
            errors++;
            $display("FAIL cleared_addr0: got %h/%h, expected 00/ff", b_rdata[0], b_rdata[1]);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        bit seen;
        idle();
        clr_req[0] = 1;
        n = 0;
        for (int c = 0; c < 1200 && n < 500; c++) begin
            tick();
            clr_req[0] = 0;
            if (clr_busy[0]) n++;
        end
        a_en[0] = 1; a_addr[0] = 10'd1;
        #2;
        rst_n = 0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({a_rdata[d], b_rdata[d], a_rvalid[d], b_rvalid[d], clr_busy[d], clr_done[d], coll[d]} !== 21'd0) begin
                errors++;
                $display("FAIL mid_clear_reset dut%0d: got %h/%h v%b%b busy%b done%b coll%b, expected all zero",
                         d, a_rdata[d], b_rdata[d], a_rvalid[d], b_rvalid[d], clr_busy[d], clr_done[d], coll[d]);
            end
        end
        idle();
        @(negedge clk);
        rst_n = 1;
        wait_clear(0, n, seen);
        checks++;
        if (!seen || n != 1024) begin
            errors++;
            $display("FAIL restart_clear_len: busy cycles %0d done_seen %0d, expected 1024 and 1", n, seen);
        end
    endtask

    initial begin
        idle();
        for (int d = 0; d < 2; d++) begin
            a_addr[d] = '0; b_addr[d] = '0; a_wdata[d] = '0; b_wdata[d] = '0;
        end
        test_reset();
        test_boot_clear();
        test_read_all();
        test_write_read();
        test_collision();
        test_rdw();
        test_random();
        test_clear_ignored();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
